// File: rtl/kv_cache_pkg.sv
// Shared definitions for kv_cache: FSM state codes, address field widths and field extraction.
// Used by the kv_cache build with or without the KV_CACHE_STATS_EN option.
package kv_cache_pkg;

    localparam int ADDR_W  = 32;
    localparam int BYTE_W  = 2;
    localparam int WORD_W  = 2;
    localparam int INDEX_W = 6;
    localparam int TAG_W   = ADDR_W - INDEX_W - WORD_W - BYTE_W;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] EVICT  = 3'd2;
    localparam logic [2:0] FREQ   = 3'd3;
    localparam logic [2:0] FWAIT  = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] addr);
        return addr[BYTE_W +: WORD_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
        return addr[BYTE_W+WORD_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/kv_cache_way.sv
// One cache way: tag, valid, dirty and line storage with combinational read,
// a single-word store port and a whole-line refill port.
module kv_cache_way
    import kv_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LINE_SIZE  = 4,
    parameter int LINE_NUM   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    index,
    output logic [TAG_W-1:0]      tag,
    output logic                  valid,
    output logic                  dirty,
    output logic [DATA_WIDTH-1:0] line [LINE_SIZE],
    input  logic                  word_we,
    input  logic [WORD_W-1:0]     word_sel,
    input  logic [DATA_WIDTH-1:0] word_data,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic [DATA_WIDTH-1:0] line_data [LINE_SIZE],
    input  logic                  clean
);

    logic [TAG_W-1:0]      tag_mem  [LINE_NUM];
    logic [DATA_WIDTH-1:0] data_mem [LINE_NUM][LINE_SIZE];
    logic [LINE_NUM-1:0]   valid_bits;
    logic [LINE_NUM-1:0]   dirty_bits;

    // Storage arrays carry no reset; only the valid/dirty flags do.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[index] <= line_tag;
            for (int k = 0; k < LINE_SIZE; k++) begin
                data_mem[index][k] <= line_data[k];
            end
        end else if (word_we) begin
            data_mem[index][word_sel] <= word_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (line_we) begin
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
        end else if (word_we) begin
            dirty_bits[index] <= 1'b1;
        end else if (clean) begin
            dirty_bits[index] <= 1'b0;
        end
    end

    assign tag   = tag_mem[index];
    assign valid = valid_bits[index];
    assign dirty = dirty_bits[index];

    always_comb begin
        for (int k = 0; k < LINE_SIZE; k++) begin
            line[k] = data_mem[index][k];
        end
    end

endmodule

// File: rtl/kv_cache.sv
// Blocking write-back, write-allocate 2-way set-associative data cache with line-wide refill/write-back.
// Optional hit/miss counters are built when KV_CACHE_STATS_EN is defined.
module kv_cache
    import kv_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAY_NUM    = 2,
    parameter int LINE_SIZE  = 4,
    parameter int LINE_NUM   = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic                  o_load_valid,
    input  logic                  i_load_ready,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    input  logic [ADDR_WIDTH-1:0] i_store_addr,
    input  logic                  i_store_valid,
    output logic                  o_store_ready,
    input  logic [DATA_WIDTH-1:0] i_fetch_data [LINE_SIZE],
    input  logic                  i_fetch_valid,
    output logic                  o_fetch_ready,
    output logic [ADDR_WIDTH-1:0] o_fetch_addr,
    output logic                  o_fetch_valid,
    input  logic                  i_fetch_ready,
    output logic [ADDR_WIDTH-1:0] o_line_addr,
    output logic [DATA_WIDTH-1:0] o_line_data [LINE_SIZE],
    output logic                  o_line_valid,
    input  logic                  i_line_ready
`ifdef KV_CACHE_STATS_EN
    ,
    output logic [31:0]           o_hit_count,
    output logic [31:0]           o_miss_count
`endif
);

    localparam int LOW_W = WORD_W + BYTE_W;

    logic [2:0]            state;
    logic [WORD_W-1:0]     req_word;
    logic [INDEX_W-1:0]    req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_store;
    logic                  victim;
    logic                  hit_way_q;
    logic [LINE_NUM-1:0]   lru;

    logic [TAG_W-1:0]      way_tag   [WAY_NUM];
    logic                  way_valid [WAY_NUM];
    logic                  way_dirty [WAY_NUM];
    logic [DATA_WIDTH-1:0] way_line  [WAY_NUM][LINE_SIZE];
    logic [WAY_NUM-1:0]    word_we;
    logic [WAY_NUM-1:0]    line_we;
    logic [WAY_NUM-1:0]    clean;

    logic hit0, hit1, hit, hit_way, miss_victim, accept;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^{i_load_addr[BYTE_W-1:0], i_store_addr[BYTE_W-1:0]};

    assign hit0        = way_valid[0] && (way_tag[0] == req_tag);
    assign hit1        = way_valid[1] && (way_tag[1] == req_tag);
    assign hit         = hit0 || hit1;
    assign hit_way     = !hit0;
    // Fill an empty way before displacing anything; otherwise take the LRU way.
    assign miss_victim = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[req_index]);
    assign accept      = (state == IDLE) && (i_load_valid || i_store_valid);

    always_comb begin
        word_we = '0;
        line_we = '0;
        clean   = '0;
        if (state == LOOKUP && hit && req_store) word_we[hit_way] = 1'b1;
        if (state == FWAIT && i_fetch_valid)     line_we[victim]  = 1'b1;
        if (state == EVICT && i_line_ready)      clean[victim]    = 1'b1;
    end

    for (genvar w = 0; w < WAY_NUM; w++) begin : g_way
        kv_cache_way #(
            .DATA_WIDTH(DATA_WIDTH),
            .LINE_SIZE (LINE_SIZE),
            .LINE_NUM  (LINE_NUM)
        ) u_way (
            .clk      (i_clk),
            .rst      (i_rst),
            .index    (req_index),
            .tag      (way_tag[w]),
            .valid    (way_valid[w]),
            .dirty    (way_dirty[w]),
            .line     (way_line[w]),
            .word_we  (word_we[w]),
            .word_sel (req_word),
            .word_data(req_data),
            .line_we  (line_we[w]),
            .line_tag (req_tag),
            .line_data(i_fetch_data),
            .clean    (clean[w])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            lru   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) state <= LOOKUP;
                LOOKUP: begin
                    if (hit) begin
                        if (req_store) begin
                            lru[req_index] <= !hit_way;
                            state          <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end else if (way_valid[miss_victim] && way_dirty[miss_victim]) begin
                        state <= EVICT;
                    end else begin
                        state <= FREQ;
                    end
                end
                EVICT: if (i_line_ready)  state <= FREQ;
                FREQ:  if (i_fetch_ready) state <= FWAIT;
                FWAIT: if (i_fetch_valid) state <= LOOKUP;
                RESP: begin
                    if (i_load_ready) begin
                        lru[req_index] <= !hit_way_q;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request latch: a load wins over a simultaneous store.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            req_store <= !i_load_valid;
            if (i_load_valid) begin
                req_word  <= addr_word(i_load_addr);
                req_index <= addr_index(i_load_addr);
                req_tag   <= addr_tag(i_load_addr);
            end else begin
                req_word  <= addr_word(i_store_addr);
                req_index <= addr_index(i_store_addr);
                req_tag   <= addr_tag(i_store_addr);
                req_data  <= i_store_data;
            end
        end
        if (state == LOOKUP) begin
            hit_way_q <= hit_way;
            if (!hit) victim <= miss_victim;
        end
    end

    assign o_load_ready  = (state == IDLE) && !i_rst;
    assign o_store_ready = (state == IDLE) && !i_load_valid && !i_rst;
    assign o_load_valid  = (state == RESP);
    assign o_load_data   = (state == RESP) ? way_line[hit_way_q][req_word] : '0;
    assign o_fetch_valid = (state == FREQ);
    assign o_fetch_addr  = (state == FREQ) ? {req_tag, req_index, {LOW_W{1'b0}}} : '0;
    assign o_fetch_ready = (state == FWAIT);
    assign o_line_valid  = (state == EVICT);
    assign o_line_addr   = (state == EVICT) ? {way_tag[victim], req_index, {LOW_W{1'b0}}} : '0;

    always_comb begin
        for (int k = 0; k < LINE_SIZE; k++) begin
            o_line_data[k] = (state == EVICT) ? way_line[victim][k] : '0;
        end
    end

`ifdef KV_CACHE_STATS_EN
    logic first_lookup;

    // Only the first lookup of a request counts; the post-refill re-lookup is ignored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            first_lookup <= 1'b0;
            o_hit_count  <= '0;
            o_miss_count <= '0;
        end else begin
            if (accept) first_lookup <= 1'b1;
            else if (state == LOOKUP) first_lookup <= 1'b0;
            if (state == LOOKUP && first_lookup) begin
                if (hit) o_hit_count  <= o_hit_count + 32'd1;
                else     o_miss_count <= o_miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_kv_cache.sv
// Bench for kv_cache: directed vector table, hand sequences for backpressure/priority/reset,
// and randomized traffic against a transparent-memory plus per-set LRU reference model.
module tb_kv_cache;

    logic        clk = 1'b0;
    logic        i_rst;
    logic [31:0] o_load_data;
    logic        o_load_valid;
    logic        i_load_ready;
    logic [31:0] i_load_addr;
    logic        i_load_valid;
    logic        o_load_ready;
    logic [31:0] i_store_data;
    logic [31:0] i_store_addr;
    logic        i_store_valid;
    logic        o_store_ready;
    logic [31:0] i_fetch_data [4];
    logic        i_fetch_valid;
    logic        o_fetch_ready;
    logic [31:0] o_fetch_addr;
    logic        o_fetch_valid;
    logic        i_fetch_ready;
    logic [31:0] o_line_addr;
    logic [31:0] o_line_data [4];
    logic        o_line_valid;
    logic        i_line_ready;

    kv_cache dut (
        .i_clk(clk), .i_rst(i_rst),
        .o_load_data(o_load_data), .o_load_valid(o_load_valid), .i_load_ready(i_load_ready),
        .i_load_addr(i_load_addr), .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_store_data(i_store_data), .i_store_addr(i_store_addr), .i_store_valid(i_store_valid),
        .o_store_ready(o_store_ready),
        .i_fetch_data(i_fetch_data), .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready),
        .o_fetch_addr(o_fetch_addr), .o_fetch_valid(o_fetch_valid), .i_fetch_ready(i_fetch_ready),
        .o_line_addr(o_line_addr), .o_line_data(o_line_data), .o_line_valid(o_line_valid),
        .i_line_ready(i_line_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Backing memory seen by the cache; words never written hold a fixed pattern.
    logic [31:0] mem [logic [31:0]];
    int          fetch_cnt = 0, evict_cnt = 0;
    logic [31:0] last_fetch_addr = '0, last_evict_addr = '0, pend_addr = '0;
    bit          pending = 0, hold_fetch = 0;

    function automatic logic [31:0] mdef(input logic [31:0] wa);
        return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] memrd(input logic [31:0] wa);
        return mem.exists(wa) ? mem[wa] : mdef(wa);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tfail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout", name);
    endtask

    task automatic chk_outputs_zero(input string name);
        logic [31:0] ld;
        ld = o_line_data[0] | o_line_data[1] | o_line_data[2] | o_line_data[3];
        chk({name, "_ctl"}, {26'd0, o_load_valid, o_load_ready, o_store_ready,
                             o_fetch_valid, o_fetch_ready, o_line_valid}, 32'd0);
        chk({name, "_data"}, o_load_data | o_fetch_addr | o_line_addr | ld, 32'd0);
    endtask

    // Memory side: random handshake delays, captures write-backs, serves refills.
    initial begin
        i_line_ready = 0; i_fetch_ready = 0; i_fetch_valid = 0;
        for (int k = 0; k < 4; k++) i_fetch_data[k] = '0;
        forever begin
            @(negedge clk);
            i_line_ready = 0; i_fetch_ready = 0; i_fetch_valid = 0;
            if (!i_rst) begin
                if (o_line_valid && $urandom_range(0, 2) != 0) begin
                    i_line_ready = 1;
                    evict_cnt++;
                    last_evict_addr = o_line_addr;
                    for (int k = 0; k < 4; k++) mem[o_line_addr + 32'(4 * k)] = o_line_data[k];
                end
                if (o_fetch_valid && $urandom_range(0, 2) != 0) begin
                    i_fetch_ready = 1;
                    fetch_cnt++;
                    last_fetch_addr = o_fetch_addr;
                    pend_addr = o_fetch_addr;
                    pending = 1;
                end else if (o_fetch_ready && pending && !hold_fetch && $urandom_range(0, 2) != 0) begin
                    i_fetch_valid = 1;
                    for (int k = 0; k < 4; k++) i_fetch_data[k] = memrd(pend_addr + 32'(4 * k));
                    pending = 0;
                end
            end
        end
    end

    task automatic cpu_load(input logic [31:0] a, input int hold, input logic [31:0] exp,
                            output logic [31:0] d, output int lat);
        int n;
        d = '0;
        lat = -1;
        @(negedge clk);
        i_load_addr = a;
        i_load_valid = 1;
        n = 0;
        while (!o_load_ready && n < 100) begin @(negedge clk); n++; end
        if (!o_load_ready) begin tfail("load_req"); i_load_valid = 0; return; end
        @(posedge clk);
        #1 i_load_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_load_valid && n < 500);
        if (!o_load_valid) begin tfail("load_resp"); return; end
        lat = n;
        d = o_load_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, o_load_valid}, 32'd1);
            chk("hold_data", o_load_data, exp);
        end
        i_load_ready = 1;
        @(posedge clk);
        #1 i_load_ready = 0;
    endtask

    task automatic cpu_store(input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        i_store_addr = a;
        i_store_data = wd;
        i_store_valid = 1;
        n = 0;
        while (!o_store_ready && n < 100) begin @(negedge clk); n++; end
        if (!o_store_ready) begin tfail("store_req"); i_store_valid = 0; return; end
        @(posedge clk);
        #1 i_store_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_load_ready && n < 500);
        if (!o_load_ready) tfail("store_done");
    endtask

    typedef struct {
        bit          st;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        bit          fetch;
        bit          evict;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl [7];

    // Reference model state for the random phase.
    logic [31:0] refw [logic [31:0]];
    logic [31:0] setq [64][$];
    bit          dirty_l [logic [31:0]];

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, a, line, wd, va;
        int lat, fc, ec, idx;
        bit hit, pexp_evict, is_st;

        i_rst = 1; i_load_valid = 0; i_load_ready = 0; i_store_valid = 0;
        i_load_addr = '0; i_store_addr = '0; i_store_data = '0;
        mem[32'h1000_1000] = 32'h0000_5555;
        mem[32'h1000_1004] = 32'h5555_0000;
        mem[32'h1000_1008] = 32'h5555_5555;
        mem[32'h1000_100C] = 32'h0505_0505;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        i_rst = 0;
        #1 chk("ready_after_reset", {30'd0, o_load_ready, o_store_ready}, 32'd3);

        tbl[0] = '{0, 32'h1000_1000, 0, 32'h0000_5555, 1, 0, 0};
        tbl[1] = '{0, 32'h1000_1008, 0, 32'h5555_5555, 0, 0, 0};
        tbl[2] = '{1, 32'h1000_1004, 32'hDEAD_BEEF, 0, 0, 0, 0};
        tbl[3] = '{0, 32'h1000_1004, 0, 32'hDEAD_BEEF, 0, 0, 0};
        tbl[4] = '{0, 32'h2000_1000, 0, mdef(32'h2000_1000), 1, 0, 0};
        tbl[5] = '{0, 32'h3000_1000, 0, mdef(32'h3000_1000), 1, 1, 32'h1000_1000};
        tbl[6] = '{0, 32'h1000_1004, 0, 32'hDEAD_BEEF, 1, 0, 0};

        for (int i = 0; i < 7; i++) begin
            fc = fetch_cnt;
            ec = evict_cnt;
            if (tbl[i].st) begin
                cpu_store(tbl[i].addr, tbl[i].wd);
            end else begin
                cpu_load(tbl[i].addr, 0, tbl[i].exp, d, lat);
                chk($sformatf("tbl%0d_data", i), d, tbl[i].exp);
                if (!tbl[i].fetch) chk($sformatf("tbl%0d_hit_latency", i), lat, 2);
            end
            chk($sformatf("tbl%0d_fetches", i), fetch_cnt - fc, {31'd0, tbl[i].fetch});
            chk($sformatf("tbl%0d_evicts", i), evict_cnt - ec, {31'd0, tbl[i].evict});
            if (tbl[i].fetch) chk($sformatf("tbl%0d_fetch_addr", i), last_fetch_addr, tbl[i].addr & ~32'hF);
            if (tbl[i].evict) chk($sformatf("tbl%0d_evict_addr", i), last_evict_addr, tbl[i].eaddr);
        end
        chk("evicted_word", memrd(32'h1000_1004), 32'hDEAD_BEEF);
        chk("evicted_word0", memrd(32'h1000_1000), 32'h0000_5555);

        // Load response held under backpressure for five cycles.
        fc = fetch_cnt;
        cpu_load(32'h1000_1008, 5, 32'h5555_5555, d, lat);
        chk("bp_data", d, 32'h5555_5555);
        chk("bp_fetches", fetch_cnt - fc, 0);

        // Simultaneous load and store to the same word: the load is served first.
        a = 32'h6000_0040;
        @(negedge clk);
        i_load_addr = a; i_load_valid = 1;
        i_store_addr = a; i_store_data = 32'h1111_2222; i_store_valid = 1;
        #1 chk("prio_ready", {30'd0, o_load_ready, o_store_ready}, 32'd2);
        @(posedge clk);
        #1 i_load_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!o_load_valid && lat < 500);
        chk("prio_load_data", o_load_data, mdef(a));
        chk("prio_store_blocked", {31'd0, o_store_ready}, 32'd0);
        i_load_ready = 1;
        @(posedge clk);
        #1 i_load_ready = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!o_store_ready && lat < 100);
        if (!o_store_ready) tfail("prio_store_req");
        @(posedge clk);
        #1 i_store_valid = 0;
        fc = fetch_cnt;
        cpu_load(a, 0, 32'h1111_2222, d, lat);
        chk("prio_store_data", d, 32'h1111_2222);
        chk("prio_fetches", fetch_cnt - fc, 0);

        // Reset while waiting for refill data.
        a = 32'h5000_2000;
        hold_fetch = 1;
        @(negedge clk);
        i_load_addr = a; i_load_valid = 1;
        @(posedge clk);
        #1 i_load_valid = 0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!o_fetch_ready && lat < 500);
        if (!o_fetch_ready) tfail("fwait_reach");
        #1 i_rst = 1;
        #1 chk_outputs_zero("mid_reset");
        @(negedge clk);
        chk_outputs_zero("mid_reset_hold");
        i_rst = 0;
        pending = 0;
        hold_fetch = 0;
        fc = fetch_cnt;
        cpu_load(a, 0, mdef(a), d, lat);
        chk("post_reset_data", d, mdef(a));
        chk("post_reset_fetches", fetch_cnt - fc, 1);

        @(negedge clk);
        i_rst = 1;
        @(negedge clk);
        i_rst = 0;

        // Randomized traffic over a few sets with more tags than ways.
        for (int n = 0; n < 120; n++) begin
            a = 32'h4000_0000 | (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                | (32'($urandom_range(0, 3)) << 2);
            is_st = ($urandom_range(0, 2) == 0);
            wd = $urandom;
            line = a & ~32'hF;
            idx = int'(a[9:4]);
            hit = 0;
            pexp_evict = 0;
            va = '0;
            for (int j = 0; j < setq[idx].size(); j++) begin
                if (setq[idx][j] == line) begin
                    hit = 1;
                    setq[idx].delete(j);
                    break;
                end
            end
            if (!hit) begin
                if (setq[idx].size() == 2) begin
                    va = setq[idx].pop_front();
                    pexp_evict = dirty_l.exists(va) && dirty_l[va];
                    dirty_l[va] = 0;
                end
                dirty_l[line] = 0;
            end
            setq[idx].push_back(line);
            fc = fetch_cnt;
            ec = evict_cnt;
            if (is_st) begin
                cpu_store(a, wd);
                refw[a] = wd;
                dirty_l[line] = 1;
            end else begin
                cpu_load(a, $urandom_range(0, 2), refw.exists(a) ? refw[a] : mdef(a), d, lat);
                chk($sformatf("rnd%0d_data", n), d, refw.exists(a) ? refw[a] : mdef(a));
            end
            chk($sformatf("rnd%0d_fetches", n), fetch_cnt - fc, {31'd0, !hit});
            chk($sformatf("rnd%0d_evicts", n), evict_cnt - ec, {31'd0, pexp_evict});
            if (pexp_evict) chk($sformatf("rnd%0d_evict_addr", n), last_evict_addr, va);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
